// File: rtl/ma_stage_if.sv
// Bundle between the execute stage, the MA stage, the data memory and writeback.
// The MA stage connects through the slave modport. The master modport is the
// view from the surrounding pipeline and memory.
interface ma_stage_if;
    logic        validEX1,       validEX2;
    logic        is_loadEX1,     is_loadEX2;
    logic        is_storeEX1,    is_storeEX2;
    logic [2:0]  funct3EX1,      funct3EX2;
    logic [31:0] aluresultEX1,   aluresultEX2;
    logic [31:0] store_dataEX1,  store_dataEX2;
    logic [4:0]  dstregEX1,      dstregEX2;
    logic        reg_weEX1,      reg_weEX2;
    logic        flush;

    logic [31:0] dmem_addr;
    logic        dmem_re;
    logic [3:0]  dmem_wstrb;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;

    logic        stall_ma;

    logic        is_loadMA1,        is_loadMA2;
    logic [31:0] aluresultMA1,      aluresultMA2;
    logic [31:0] load_reg_valueMA1, load_reg_valueMA2;
    logic [4:0]  dstregMA1,         dstregMA2;
    logic        reg_weMA1,         reg_weMA2;

    modport slave (
        input  validEX1, validEX2, is_loadEX1, is_loadEX2,
        input  is_storeEX1, is_storeEX2, funct3EX1, funct3EX2,
        input  aluresultEX1, aluresultEX2, store_dataEX1, store_dataEX2,
        input  dstregEX1, dstregEX2, reg_weEX1, reg_weEX2, flush,
        input  dmem_rdata,
        output dmem_addr, dmem_re, dmem_wstrb, dmem_wdata, stall_ma,
        output is_loadMA1, is_loadMA2, aluresultMA1, aluresultMA2,
        output load_reg_valueMA1, load_reg_valueMA2,
        output dstregMA1, dstregMA2, reg_weMA1, reg_weMA2
    );

    modport master (
        output validEX1, validEX2, is_loadEX1, is_loadEX2,
        output is_storeEX1, is_storeEX2, funct3EX1, funct3EX2,
        output aluresultEX1, aluresultEX2, store_dataEX1, store_dataEX2,
        output dstregEX1, dstregEX2, reg_weEX1, reg_weEX2, flush,
        output dmem_rdata,
        input  dmem_addr, dmem_re, dmem_wstrb, dmem_wdata, stall_ma,
        input  is_loadMA1, is_loadMA2, aluresultMA1, aluresultMA2,
        input  load_reg_valueMA1, load_reg_valueMA2,
        input  dstregMA1, dstregMA2, reg_weMA1, reg_weMA2
    );
endinterface

// File: rtl/ma_stage.sv
// Dual-issue memory-access stage with the MA/RW pipeline register.
// There is one single-port, synchronous-read data memory. When both slots need
// it in the same cycle, the two accesses are serialized: slot 1 goes first, and
// upstream is stalled for one cycle.
//
// state  | meaning
// RUN    | normal issue; at most one memory access; detects a memory pair
// SECOND | slot 1 of a pair was accessed last cycle; slot 2 accesses now
module ma_stage (
    input  logic      clk,
    input  logic      rst,
    ma_stage_if.slave ma
);

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        SECOND = 1'b1
    } state_t;

    // Extracts the load value from a read word, using the width/sign code and the
    // byte offset.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  lo);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lo)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lo[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b100:  r = {24'd0, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b101:  r = {16'd0, h};
            3'b010:  r = word;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Byte lanes for a store. Misaligned offsets still select lanes from addr[1:0].
    function automatic logic [3:0] store_strb(input logic [2:0] f3,
                                              input logic [1:0] lo);
        logic [3:0] s;
        case (f3)
            3'b000:  s = 4'b0001 << lo;
            3'b001:  s = lo[1] ? 4'b1100 : 4'b0011;
            3'b010:  s = 4'b1111;
            default: s = 4'b0000;
        endcase
        return s;
    endfunction

    // Replicates the store data across lanes, so the strobe alone picks the bytes.
    function automatic logic [31:0] store_wdata(input logic [2:0]  f3,
                                                input logic [31:0] data);
        logic [31:0] w;
        case (f3)
            3'b000:  w = {4{data[7:0]}};
            3'b001:  w = {2{data[15:0]}};
            default: w = data;
        endcase
        return w;
    endfunction

    state_t      state_q, state_d;
    logic [2:0]  pend_f3_q, pend_f3_d;
    logic [1:0]  pend_lo_q, pend_lo_d;
    logic [31:0] hold_q, hold_d;

    logic        is_load1_q, is_load1_d, is_load2_q, is_load2_d;
    logic [31:0] alu1_q, alu1_d, alu2_q, alu2_d;
    logic [4:0]  dst1_q, dst1_d, dst2_q, dst2_d;
    logic        we1_q, we1_d, we2_q, we2_d;
    logic [2:0]  f3_1_q, f3_1_d, f3_2_q, f3_2_d;
    logic [1:0]  lo1_q, lo1_d, lo2_q, lo2_d;
    logic        use_hold_q, use_hold_d;

    logic        mem1, mem2;
    logic        acc_en, acc_sel2, stall, bubble;
    logic [31:0] acc_addr, acc_data;
    logic [2:0]  acc_f3;
    logic        acc_ld, acc_st;

    assign mem1 = ma.validEX1 & (ma.is_loadEX1 | ma.is_storeEX1);
    assign mem2 = ma.validEX2 & (ma.is_loadEX2 | ma.is_storeEX2);

    // Sequencing: chooses which slot uses memory, raises stall, and marks bubbles.
    always_comb begin
        state_d   = state_q;
        acc_en    = 1'b0;
        acc_sel2  = 1'b0;
        stall     = 1'b0;
        bubble    = 1'b0;
        pend_f3_d = pend_f3_q;
        pend_lo_d = pend_lo_q;
        hold_d    = hold_q;
        case (state_q)
            RUN: begin
                if (ma.flush) begin
                    bubble = 1'b1;
                end else if (mem1 && mem2) begin
                    acc_en    = 1'b1;
                    stall     = 1'b1;
                    bubble    = 1'b1;
                    pend_f3_d = ma.funct3EX1;
                    pend_lo_d = ma.aluresultEX1[1:0];
                    state_d   = SECOND;
                end else begin
                    acc_en   = mem1 | mem2;
                    acc_sel2 = ~mem1;
                end
            end
            SECOND: begin
                state_d = RUN;
                if (ma.flush) begin
                    bubble = 1'b1;
                end else begin
                    acc_en   = 1'b1;
                    acc_sel2 = 1'b1;
                    hold_d   = load_extract(ma.dmem_rdata, pend_f3_q, pend_lo_q);
                end
            end
            default: state_d = RUN;
        endcase
        // Reset asserted between edges silences the memory port and the stall.
        if (rst) begin
            acc_en = 1'b0;
            stall  = 1'b0;
        end
    end

    // Steers the memory port to the slot selected for this cycle.
    always_comb begin
        acc_addr = acc_sel2 ? ma.aluresultEX2  : ma.aluresultEX1;
        acc_data = acc_sel2 ? ma.store_dataEX2 : ma.store_dataEX1;
        acc_f3   = acc_sel2 ? ma.funct3EX2     : ma.funct3EX1;
        acc_ld   = acc_sel2 ? ma.is_loadEX2    : ma.is_loadEX1;
        acc_st   = acc_sel2 ? ma.is_storeEX2   : ma.is_storeEX1;
    end

    assign ma.dmem_addr  = {acc_addr[31:2], 2'b00};
    assign ma.dmem_re    = acc_en & acc_ld;
    assign ma.dmem_wstrb = (acc_en & acc_st) ? store_strb(acc_f3, acc_addr[1:0]) : 4'b0000;
    assign ma.dmem_wdata = store_wdata(acc_f3, acc_data);
    assign ma.stall_ma   = stall;

    // MA register next value: capture both slots, or load an all-zero bubble.
    always_comb begin
        is_load1_d = ma.validEX1 & ma.is_loadEX1;
        is_load2_d = ma.validEX2 & ma.is_loadEX2;
        alu1_d     = ma.aluresultEX1;
        alu2_d     = ma.aluresultEX2;
        dst1_d     = ma.dstregEX1;
        dst2_d     = ma.dstregEX2;
        we1_d      = ma.validEX1 & ma.reg_weEX1;
        we2_d      = ma.validEX2 & ma.reg_weEX2;
        f3_1_d     = ma.funct3EX1;
        f3_2_d     = ma.funct3EX2;
        lo1_d      = ma.aluresultEX1[1:0];
        lo2_d      = ma.aluresultEX2[1:0];
        use_hold_d = (state_q == SECOND);
        if (bubble) begin
            is_load1_d = 1'b0;
            is_load2_d = 1'b0;
            alu1_d     = 32'd0;
            alu2_d     = 32'd0;
            dst1_d     = 5'd0;
            dst2_d     = 5'd0;
            we1_d      = 1'b0;
            we2_d      = 1'b0;
            f3_1_d     = 3'd0;
            f3_2_d     = 3'd0;
            lo1_d      = 2'd0;
            lo2_d      = 2'd0;
            use_hold_d = 1'b0;
        end
    end

    // Registers the FSM, the pending slot-1 load shape, the hold value and the MA bundle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            pend_f3_q  <= 3'd0;
            pend_lo_q  <= 2'd0;
            hold_q     <= 32'd0;
            is_load1_q <= 1'b0;
            is_load2_q <= 1'b0;
            alu1_q     <= 32'd0;
            alu2_q     <= 32'd0;
            dst1_q     <= 5'd0;
            dst2_q     <= 5'd0;
            we1_q      <= 1'b0;
            we2_q      <= 1'b0;
            f3_1_q     <= 3'd0;
            f3_2_q     <= 3'd0;
            lo1_q      <= 2'd0;
            lo2_q      <= 2'd0;
            use_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_f3_q  <= pend_f3_d;
            pend_lo_q  <= pend_lo_d;
            hold_q     <= hold_d;
            is_load1_q <= is_load1_d;
            is_load2_q <= is_load2_d;
            alu1_q     <= alu1_d;
            alu2_q     <= alu2_d;
            dst1_q     <= dst1_d;
            dst2_q     <= dst2_d;
            we1_q      <= we1_d;
            we2_q      <= we2_d;
            f3_1_q     <= f3_1_d;
            f3_2_q     <= f3_2_d;
            lo1_q      <= lo1_d;
            lo2_q      <= lo2_d;
            use_hold_q <= use_hold_d;
        end
    end

    // Load values are decoded from the read data the cycle after capture. The
    // exception is slot 1 of a serialized pair: its data was read one cycle
    // earlier, so it comes from the hold register.
    always_comb begin
        ma.load_reg_valueMA1 = 32'd0;
        ma.load_reg_valueMA2 = 32'd0;
        if (is_load1_q)
            ma.load_reg_valueMA1 = use_hold_q ? hold_q : load_extract(ma.dmem_rdata, f3_1_q, lo1_q);
        if (is_load2_q)
            ma.load_reg_valueMA2 = load_extract(ma.dmem_rdata, f3_2_q, lo2_q);
    end

    assign ma.is_loadMA1   = is_load1_q;
    assign ma.is_loadMA2   = is_load2_q;
    assign ma.aluresultMA1 = alu1_q;
    assign ma.aluresultMA2 = alu2_q;
    assign ma.dstregMA1    = dst1_q;
    assign ma.dstregMA2    = dst2_q;
    assign ma.reg_weMA1    = we1_q;
    assign ma.reg_weMA2    = we2_q;

endmodule

// File: tb/tb_ma_stage.sv
// Testbench for ma_stage. It emulates the data memory, runs directed
// scenarios, then applies random dual-issue bundles. The random traffic is
// checked against a transaction-level model that keeps its own copy of memory.
module tb_ma_stage;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ma_stage_if bus();

    ma_stage dut (
        .clk (clk),
        .rst (rst),
        .ma  (bus)
    );

    logic [31:0] mem       [0:255];
    logic [31:0] model_mem [0:255];

    // Synchronous-read, byte-writable data memory.
    always @(posedge clk) begin
        if (bus.dmem_re) bus.dmem_rdata <= mem[bus.dmem_addr[9:2]];
        for (int b = 0; b < 4; b++)
            if (bus.dmem_wstrb[b]) mem[bus.dmem_addr[9:2]][8*b +: 8] <= bus.dmem_wdata[8*b +: 8];
    end

    // ---------------- reference model (plain arithmetic on words) ----------------
    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
        int unsigned b, h;
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return (b >= 128) ? b - 256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 65536 : h;
            3'd5:    return h;
            3'd2:    return w;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [2:0] f3,
                                              input logic [31:0] a, input logic [31:0] d);
        logic [31:0] mask;
        case (f3)
            3'd0: begin
                mask = 32'hFF << (8 * a[1:0]);
                return (w & ~mask) | ((d & 32'hFF) << (8 * a[1:0]));
            end
            3'd1: begin
                mask = 32'hFFFF << (16 * a[1]);
                return (w & ~mask) | ((d & 32'hFFFF) << (16 * a[1]));
            end
            3'd2:    return d;
            default: return w;
        endcase
    endfunction

    // A lane is written exactly when storing all-ones into a zero word touches it.
    function automatic logic [3:0] ref_strb(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] m;
        logic [3:0]  s;
        m = ref_store(32'd0, f3, a, 32'hFFFFFFFF);
        for (int i = 0; i < 4; i++) s[i] = (m[8*i +: 8] != 8'd0);
        return s;
    endfunction

    task automatic model_apply(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] d, output logic [31:0] val);
        val = 32'd0;
        if (ld) val = ref_load(model_mem[a[9:2]], f3, a);
        if (st) model_mem[a[9:2]] = ref_store(model_mem[a[9:2]], f3, a, d);
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic poke(input int idx, input logic [31:0] val);
        mem[idx] <= val;
        model_mem[idx] = val;
    endtask

    task automatic drive1(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input logic [4:0] dst, input logic we);
        bus.validEX1 = v; bus.is_loadEX1 = ld; bus.is_storeEX1 = st; bus.funct3EX1 = f3;
        bus.aluresultEX1 = a; bus.store_dataEX1 = d; bus.dstregEX1 = dst; bus.reg_weEX1 = we;
    endtask

    task automatic drive2(input logic v, input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] d, input logic [4:0] dst, input logic we);
        bus.validEX2 = v; bus.is_loadEX2 = ld; bus.is_storeEX2 = st; bus.funct3EX2 = f3;
        bus.aluresultEX2 = a; bus.store_dataEX2 = d; bus.dstregEX2 = dst; bus.reg_weEX2 = we;
    endtask

    task automatic idle();
        drive1(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 0);
        drive2(0, 0, 0, 3'd0, 32'd0, 32'd0, 5'd0, 0);
        bus.flush = 1'b0;
    endtask

    // ---------------- directed scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle();
        for (int i = 0; i < 256; i++) poke(i, 32'd0);
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.is_loadMA1, bus.is_loadMA2, bus.aluresultMA1, bus.aluresultMA2, bus.load_reg_valueMA1,
             bus.load_reg_valueMA2, bus.dstregMA1, bus.dstregMA2, bus.reg_weMA1, bus.reg_weMA2} !== 142'd0) begin
            n_fail++;
            $display("FAIL reset_ma: MA outputs not all zero (we1=%b we2=%b alu1=%h)", bus.reg_weMA1, bus.reg_weMA2, bus.aluresultMA1);
        end
        n_checks++;
        if ({bus.stall_ma, bus.dmem_re, bus.dmem_wstrb} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_ctrl: stall/re/wstrb got %b expected 000000", {bus.stall_ma, bus.dmem_re, bus.dmem_wstrb});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lb_single();
        poke(32'h40, 32'h8081F0F7);
        @(negedge clk);
        drive1(1, 1, 0, 3'b000, 32'h103, 32'd0, 5'd5, 1);
        #1;
        n_checks++;
        if ({bus.dmem_re, bus.stall_ma, bus.dmem_addr} !== {1'b1, 1'b0, 32'h100}) begin
            n_fail++;
            $display("FAIL lb_access: re=%b stall=%b addr=%h expected re=1 stall=0 addr=00000100", bus.dmem_re, bus.stall_ma, bus.dmem_addr);
        end
        @(negedge clk);
        n_checks++;
        if ({bus.load_reg_valueMA1, bus.reg_weMA1, bus.dstregMA1} !== {32'hFFFFFF80, 1'b1, 5'd5}) begin
            n_fail++;
            $display("FAIL lb_result: val=%h we=%b dst=%0d expected FFFFFF80 1 5", bus.load_reg_valueMA1, bus.reg_weMA1, bus.dstregMA1);
        end
        idle();
    endtask

    task automatic test_sh_store();
        logic [31:0] unused;
        drive1(1, 0, 1, 3'b001, 32'h202, 32'h1234ABCD, 5'd0, 0);
        drive2(1, 0, 0, 3'b000, 32'd7, 32'd0, 5'd3, 1);
        #1;
        n_checks++;
        if ({bus.stall_ma, bus.dmem_re, bus.dmem_wstrb, bus.dmem_wdata} !== {1'b0, 1'b0, 4'b1100, 32'hABCDABCD}) begin
            n_fail++;
            $display("FAIL sh_lanes: stall=%b re=%b wstrb=%b wdata=%h expected 0 0 1100 ABCDABCD",
                     bus.stall_ma, bus.dmem_re, bus.dmem_wstrb, bus.dmem_wdata);
        end
        model_apply(0, 1, 3'b001, 32'h202, 32'h1234ABCD, unused);
        @(negedge clk);
        n_checks++;
        if ({bus.aluresultMA2, bus.reg_weMA2, bus.dstregMA2, bus.reg_weMA1} !== {32'd7, 1'b1, 5'd3, 1'b0}) begin
            n_fail++;
            $display("FAIL sh_alu_slot: alu2=%h we2=%b dst2=%0d we1=%b expected 7 1 3 0",
                     bus.aluresultMA2, bus.reg_weMA2, bus.dstregMA2, bus.reg_weMA1);
        end
        idle();
    endtask

    task automatic test_lw_pair();
        poke(4, 32'h11111111);
        poke(5, 32'h22222222);
        @(negedge clk);
        drive1(1, 1, 0, 3'b010, 32'h10, 32'd0, 5'd1, 1);
        drive2(1, 1, 0, 3'b010, 32'h14, 32'd0, 5'd2, 1);
        #1;
        n_checks++;
        if ({bus.stall_ma, bus.dmem_re, bus.dmem_addr} !== {1'b1, 1'b1, 32'h10}) begin
            n_fail++;
            $display("FAIL pair_first: stall=%b re=%b addr=%h expected 1 1 00000010", bus.stall_ma, bus.dmem_re, bus.dmem_addr);
        end
        @(negedge clk);
        n_checks++;
        if ({bus.reg_weMA1, bus.reg_weMA2, bus.is_loadMA1, bus.is_loadMA2} !== 4'b0000) begin
            n_fail++;
            $display("FAIL pair_bubble: we1/we2/ld1/ld2 got %b expected 0000",
                     {bus.reg_weMA1, bus.reg_weMA2, bus.is_loadMA1, bus.is_loadMA2});
        end
        #1;
        n_checks++;
        if ({bus.stall_ma, bus.dmem_re, bus.dmem_addr} !== {1'b0, 1'b1, 32'h14}) begin
            n_fail++;
            $display("FAIL pair_second: stall=%b re=%b addr=%h expected 0 1 00000014", bus.stall_ma, bus.dmem_re, bus.dmem_addr);
        end
        @(negedge clk);
        n_checks++;
        if ({bus.load_reg_valueMA1, bus.load_reg_valueMA2, bus.reg_weMA1, bus.reg_weMA2, bus.dstregMA1, bus.dstregMA2}
            !== {32'h11111111, 32'h22222222, 1'b1, 1'b1, 5'd1, 5'd2}) begin
            n_fail++;
            $display("FAIL pair_result: v1=%h v2=%h we=%b%b expected 11111111 22222222 11",
                     bus.load_reg_valueMA1, bus.load_reg_valueMA2, bus.reg_weMA1, bus.reg_weMA2);
        end
        idle();
    endtask

    task automatic test_store_load_pair();
        logic [31:0] unused;
        drive1(1, 0, 1, 3'b010, 32'h40, 32'hDEADBEEF, 5'd0, 0);
        drive2(1, 1, 0, 3'b100, 32'h41, 32'd0, 5'd9, 1);
        #1;
        n_checks++;
        if ({bus.stall_ma, bus.dmem_re, bus.dmem_wstrb} !== {1'b1, 1'b0, 4'b1111}) begin
            n_fail++;
            $display("FAIL stld_store: stall=%b re=%b wstrb=%b expected 1 0 1111", bus.stall_ma, bus.dmem_re, bus.dmem_wstrb);
        end
        model_apply(0, 1, 3'b010, 32'h40, 32'hDEADBEEF, unused);
        @(negedge clk);
        #1;
        n_checks++;
        if ({bus.dmem_re, bus.dmem_wstrb, bus.dmem_addr} !== {1'b1, 4'b0000, 32'h40}) begin
            n_fail++;
            $display("FAIL stld_load: re=%b wstrb=%b addr=%h expected 1 0000 00000040", bus.dmem_re, bus.dmem_wstrb, bus.dmem_addr);
        end
        @(negedge clk);
        n_checks++;
        if ({bus.load_reg_valueMA2, bus.reg_weMA2, bus.dstregMA2, bus.reg_weMA1} !== {32'h000000BE, 1'b1, 5'd9, 1'b0}) begin
            n_fail++;
            $display("FAIL stld_result: v2=%h we2=%b dst2=%0d we1=%b expected 000000BE 1 9 0",
                     bus.load_reg_valueMA2, bus.reg_weMA2, bus.dstregMA2, bus.reg_weMA1);
        end
        idle();
    endtask

    task automatic test_flush_second();
        drive1(1, 1, 0, 3'b010, 32'h10, 32'd0, 5'd1, 1);
        drive2(1, 1, 0, 3'b010, 32'h14, 32'd0, 5'd2, 1);
        @(negedge clk);
        bus.flush = 1'b1;
        #1;
        n_checks++;
        if ({bus.stall_ma, bus.dmem_re, bus.dmem_wstrb} !== 6'd0) begin
            n_fail++;
            $display("FAIL flush_access: stall/re/wstrb got %b expected 000000", {bus.stall_ma, bus.dmem_re, bus.dmem_wstrb});
        end
        @(negedge clk);
        n_checks++;
        if ({bus.reg_weMA1, bus.reg_weMA2, bus.is_loadMA1, bus.is_loadMA2} !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush_bubble: we1/we2/ld1/ld2 got %b expected 0000",
                     {bus.reg_weMA1, bus.reg_weMA2, bus.is_loadMA1, bus.is_loadMA2});
        end
        bus.flush = 1'b0;
        drive1(1, 1, 0, 3'b010, 32'h14, 32'd0, 5'd3, 1);
        drive2(1, 1, 0, 3'b010, 32'h10, 32'd0, 5'd4, 1);
        #1;
        n_checks++;
        if ({bus.stall_ma, bus.dmem_addr} !== {1'b1, 32'h14}) begin
            n_fail++;
            $display("FAIL flush_repair: stall=%b addr=%h expected 1 00000014", bus.stall_ma, bus.dmem_addr);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.load_reg_valueMA1, bus.load_reg_valueMA2} !== {32'h22222222, 32'h11111111}) begin
            n_fail++;
            $display("FAIL flush_pair_result: v1=%h v2=%h expected 22222222 11111111", bus.load_reg_valueMA1, bus.load_reg_valueMA2);
        end
        idle();
    endtask

    task automatic test_async_reset();
        poke(0, 32'h80018002);
        drive1(1, 1, 0, 3'b010, 32'h10, 32'd0, 5'd1, 1);
        drive2(1, 1, 0, 3'b010, 32'h14, 32'd0, 5'd2, 1);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.stall_ma, bus.dmem_re, bus.dmem_wstrb, bus.reg_weMA1, bus.reg_weMA2, bus.is_loadMA1, bus.is_loadMA2,
             bus.aluresultMA1, bus.aluresultMA2, bus.load_reg_valueMA1, bus.load_reg_valueMA2} !== 138'd0) begin
            n_fail++;
            $display("FAIL async_reset: stall=%b re=%b wstrb=%b we=%b%b expected all zero",
                     bus.stall_ma, bus.dmem_re, bus.dmem_wstrb, bus.reg_weMA1, bus.reg_weMA2);
        end
        idle();
        #1;
        rst = 1'b0;
        @(negedge clk);
        drive1(1, 1, 0, 3'b101, 32'h2, 32'd0, 5'd4, 1);
        #1;
        n_checks++;
        if ({bus.stall_ma, bus.dmem_re, bus.dmem_addr} !== {1'b0, 1'b1, 32'h0}) begin
            n_fail++;
            $display("FAIL post_reset_access: stall=%b re=%b addr=%h expected 0 1 00000000", bus.stall_ma, bus.dmem_re, bus.dmem_addr);
        end
        @(negedge clk);
        n_checks++;
        if ({bus.load_reg_valueMA1, bus.reg_weMA1, bus.dstregMA1} !== {32'h00008001, 1'b1, 5'd4}) begin
            n_fail++;
            $display("FAIL post_reset_lhu: val=%h we=%b dst=%0d expected 00008001 1 4", bus.load_reg_valueMA1, bus.reg_weMA1, bus.dstregMA1);
        end
        idle();
    endtask

    // ---------------- randomized traffic against the model ----------------
    task automatic test_random(input int iters);
        for (int it = 0; it < iters; it++) begin
            logic        v [0:1], ld [0:1], st [0:1], we [0:1], m [0:1];
            logic [2:0]  f3 [0:1];
            logic [31:0] a [0:1], d [0:1], expval [0:1];
            logic [4:0]  dst [0:1];
            logic        fl, fl2, pair, exp_re;
            logic [3:0]  exp_strb;
            logic [31:0] lane_mask;
            int          acc, kind, r;
            for (int s = 0; s < 2; s++) begin
                kind  = $urandom_range(0, 2);
                v[s]  = ($urandom_range(0, 3) != 0);
                ld[s] = (kind == 1);
                st[s] = (kind == 2);
                r     = $urandom_range(0, 9);
                case (r)
                    0, 1:    f3[s] = 3'd0;
                    2, 3:    f3[s] = 3'd1;
                    4, 5:    f3[s] = 3'd2;
                    6:       f3[s] = 3'd4;
                    7:       f3[s] = 3'd5;
                    8:       f3[s] = 3'd3;
                    default: f3[s] = 3'd7;
                endcase
                a[s]      = (kind != 0) ? 32'($urandom_range(0, 1023)) : $urandom;
                d[s]      = $urandom;
                dst[s]    = 5'($urandom_range(0, 31));
                we[s]     = 1'($urandom_range(0, 1));
                m[s]      = v[s] & (ld[s] | st[s]);
                expval[s] = 32'd0;
            end
            fl   = ($urandom_range(0, 9) == 0);
            pair = m[0] & m[1] & ~fl;
            drive1(v[0], ld[0], st[0], f3[0], a[0], d[0], dst[0], we[0]);
            drive2(v[1], ld[1], st[1], f3[1], a[1], d[1], dst[1], we[1]);
            bus.flush = fl;
            acc = fl ? -1 : (m[0] ? 0 : (m[1] ? 1 : -1));
            #1;
            exp_re   = (acc >= 0) ? ld[acc] : 1'b0;
            exp_strb = (acc >= 0 && st[acc]) ? ref_strb(f3[acc], a[acc]) : 4'd0;
            n_checks++;
            if ({bus.stall_ma, bus.dmem_re, bus.dmem_wstrb} !== {pair, exp_re, exp_strb}) begin
                n_fail++;
                $display("FAIL rnd_ctrl it=%0d: stall/re/wstrb got %b expected %b", it,
                         {bus.stall_ma, bus.dmem_re, bus.dmem_wstrb}, {pair, exp_re, exp_strb});
            end
            if (acc >= 0) begin
                n_checks++;
                if (bus.dmem_addr !== {a[acc][31:2], 2'b00}) begin
                    n_fail++;
                    $display("FAIL rnd_addr it=%0d: got %h expected %h", it, bus.dmem_addr, {a[acc][31:2], 2'b00});
                end
                lane_mask = ref_store(32'd0, f3[acc], a[acc], 32'hFFFFFFFF);
                if (exp_strb != 4'd0) begin
                    n_checks++;
                    if ((bus.dmem_wdata & lane_mask) !== ref_store(32'd0, f3[acc], a[acc], d[acc])) begin
                        n_fail++;
                        $display("FAIL rnd_wdata it=%0d: got %h expected lanes %h", it, bus.dmem_wdata & lane_mask,
                                 ref_store(32'd0, f3[acc], a[acc], d[acc]));
                    end
                end
                model_apply(ld[acc], st[acc], f3[acc], a[acc], d[acc], expval[acc]);
            end
            fl2 = 1'b0;
            if (pair) begin
                @(negedge clk);
                n_checks++;
                if ({bus.reg_weMA1, bus.reg_weMA2, bus.is_loadMA1, bus.is_loadMA2} !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL rnd_bubble it=%0d: we1/we2/ld1/ld2 got %b expected 0000", it,
                             {bus.reg_weMA1, bus.reg_weMA2, bus.is_loadMA1, bus.is_loadMA2});
                end
                fl2 = ($urandom_range(0, 9) == 0);
                bus.flush = fl2;
                #1;
                exp_re   = fl2 ? 1'b0 : ld[1];
                exp_strb = (!fl2 && st[1]) ? ref_strb(f3[1], a[1]) : 4'd0;
                n_checks++;
                if ({bus.stall_ma, bus.dmem_re, bus.dmem_wstrb} !== {1'b0, exp_re, exp_strb}
                    || (!fl2 && bus.dmem_addr !== {a[1][31:2], 2'b00})) begin
                    n_fail++;
                    $display("FAIL rnd_second it=%0d: stall/re/wstrb got %b expected %b addr=%h", it,
                             {bus.stall_ma, bus.dmem_re, bus.dmem_wstrb}, {1'b0, exp_re, exp_strb}, bus.dmem_addr);
                end
                if (!fl2) model_apply(ld[1], st[1], f3[1], a[1], d[1], expval[1]);
            end
            @(negedge clk);
            bus.flush = 1'b0;
            if (fl || fl2) begin
                n_checks++;
                if ({bus.reg_weMA1, bus.reg_weMA2, bus.is_loadMA1, bus.is_loadMA2} !== 4'b0000) begin
                    n_fail++;
                    $display("FAIL rnd_flush it=%0d: we1/we2/ld1/ld2 got %b expected 0000", it,
                             {bus.reg_weMA1, bus.reg_weMA2, bus.is_loadMA1, bus.is_loadMA2});
                end
            end else begin
                n_checks++;
                if ({bus.reg_weMA1, bus.is_loadMA1, bus.reg_weMA2, bus.is_loadMA2}
                    !== {v[0] & we[0], v[0] & ld[0], v[1] & we[1], v[1] & ld[1]}) begin
                    n_fail++;
                    $display("FAIL rnd_flags it=%0d: got %b expected %b", it,
                             {bus.reg_weMA1, bus.is_loadMA1, bus.reg_weMA2, bus.is_loadMA2},
                             {v[0] & we[0], v[0] & ld[0], v[1] & we[1], v[1] & ld[1]});
                end
                if (v[0]) begin
                    n_checks++;
                    if ({bus.aluresultMA1, bus.dstregMA1} !== {a[0], dst[0]}
                        || (ld[0] && bus.load_reg_valueMA1 !== expval[0])) begin
                        n_fail++;
                        $display("FAIL rnd_slot1 it=%0d: alu=%h dst=%0d val=%h expected alu=%h dst=%0d val=%h", it,
                                 bus.aluresultMA1, bus.dstregMA1, bus.load_reg_valueMA1, a[0], dst[0], expval[0]);
                    end
                end
                if (v[1]) begin
                    n_checks++;
                    if ({bus.aluresultMA2, bus.dstregMA2} !== {a[1], dst[1]}
                        || (ld[1] && bus.load_reg_valueMA2 !== expval[1])) begin
                        n_fail++;
                        $display("FAIL rnd_slot2 it=%0d: alu=%h dst=%0d val=%h expected alu=%h dst=%0d val=%h", it,
                                 bus.aluresultMA2, bus.dstregMA2, bus.load_reg_valueMA2, a[1], dst[1], expval[1]);
                    end
                end
            end
        end
        idle();
        @(negedge clk);
    endtask

    task automatic test_memory_image();
        int bad;
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== model_mem[i]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL memory_image: %0d words differ from the model, expected 0", bad);
        end
    endtask

    initial begin
        test_reset();
        test_lb_single();
        test_sh_store();
        test_lw_pair();
        test_store_load_pair();
        test_flush_second();
        test_async_reset();
        test_random(400);
        test_memory_image();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ma_stage.md
# ma_stage

Dual-issue memory-access stage with the MA/RW pipeline register. It takes two execute-stage instruction slots and performs their loads and stores through a single-port, synchronous-read data memory. It then registers the results (ALU result, load value, destination register, write enable) for the writeback stage. When both slots carry memory operations in the same cycle, it serializes them in program order (slot 1 first) and stalls upstream for one cycle.

## Interface
Parameters: none.
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- validEX1, validEX2  input  1  slot carries a live instruction
- is_loadEX1, is_loadEX2  input  1  slot is a load
- is_storeEX1, is_storeEX2  input  1  slot is a store (never both load and store)
- funct3EX1, funct3EX2  input  3  RV32I width/sign code
- aluresultEX1, aluresultEX2  input  32  ALU result; byte address for loads/stores
- store_dataEX1, store_dataEX2  input  32  rs2 value for stores
- dstregEX1, dstregEX2  input  5  destination register
- reg_weEX1, reg_weEX2  input  1  register write enable
- flush  input  1  kill everything presented this cycle and abort the pending second access
- dmem_addr  output  32  word-aligned address ({addr[31:2],2'b00})
- dmem_re  output  1  read strobe
- dmem_wstrb  output  4  byte write enables; 0 = no write
- dmem_wdata  output  32  lane-replicated store data
- dmem_rdata  input  32  read data; valid the cycle after dmem_re
- stall_ma  output  1  upstream must hold its EX bundle this cycle
- is_loadMA1/2, aluresultMA1/2, load_reg_valueMA1/2, dstregMA1/2, reg_weMA1/2  output  1/32/32/5/1  bundle to writeback

## Operation
- Memory slot: valid and (is_load or is_store). At most one memory access per cycle.
- FSM states: RUN and SECOND.
- RUN, at most one memory slot:
  - The memory slot accesses memory this cycle.
  - Both slots are captured into the MA register at the edge.
  - stall_ma=0.
- RUN, both slots are memory slots and flush=0:
  - Slot 1 accesses memory this cycle.
  - stall_ma=1.
  - The MA register loads a bubble (reg_weMA1/2=0, is_loadMA1/2=0).
  - Next state is SECOND.
- SECOND:
  - Slot 1 load data (dmem_rdata) is extracted into the hold register.
  - Slot 2 (still held by upstream) accesses memory.
  - stall_ma=0.
  - Both slots are captured into the MA register.
  - Next state is RUN.
- Load extraction uses the registered funct3 and addr[1:0]:
  - LB (000) / LBU (100): byte selected by addr[1:0], sign- or zero-extended.
  - LH (001) / LHU (101): half selected by addr[1], sign- or zero-extended.
  - LW (010): full word.
- load_reg_valueMA is combinational from dmem_rdata in the cycle after capture. The exception is slot 1 of a serialized pair, which comes from the hold register.
- Store lanes:
  - SB: wstrb=4'b0001<<addr[1:0]; wdata = byte replicated ×4.
  - SH: wstrb=4'b0011<<{addr[1],1'b0}; wdata = half replicated ×2.
  - SW: wstrb=4'b1111.
- Invalid slots write nothing and give reg_weMA=0.
- Misaligned halfword and word accesses are outside the contract: lanes are derived from addr[1:0] regardless.
- Unused funct3 codes give load value 0 and wstrb 0.
- flush:
  - Forces a bubble into the MA register.
  - Suppresses the dmem access of the current cycle (wstrb=0, re=0).
  - Returns the FSM to RUN.
  - Deasserts stall_ma.

## Timing
- Reset values:
  - FSM is RUN; hold register is 0.
  - All MA outputs are 0.
  - stall_ma=0, dmem_re=0, dmem_wstrb=0.
- Latency: EX bundle to MA outputs is 1 cycle. A serialized pair takes 2 cycles; the slot 1 result appears with slot 2, never earlier.
- dmem_addr/re/wstrb/wdata are combinational from the EX inputs and the state.
- Stores commit at the edge ending their access cycle.
- Serialized store-then-load to the same word: the load returns the newly stored data.
- stall_ma is high only in the RUN cycle that detects a pair. It is never high for two consecutive cycles.
- Reset mid-pair (in SECOND): slot 2 access is abandoned, the hold is cleared, and the MA outputs go to 0.

## Test plan
- Reset with mem[0x100]=0x8081F0F7, then slot 1 LB at 0x103 with dstreg 5 → dmem_re=1, addr 0x100. Next cycle load_reg_valueMA1=0xFFFFFF80, reg_weMA1=1, dstregMA1=5.
- Slot 1 SH of 0x1234ABCD at 0x202, slot 2 ADD result 7 → wstrb=1100, wdata=0xABCDABCD, stall_ma=0. Next cycle aluresultMA2=7.
- Both slots LW (0x10→0x11111111, 0x14→0x22222222) → stall_ma=1 for one cycle and a bubble (reg_we=0). Then both values appear in the same cycle.
- Slot 1 SW 0xDEADBEEF at 0x40 and slot 2 LBU at 0x41, same cycle → serialized. load_reg_valueMA2=0x000000BE.
- Flush asserted in the SECOND cycle → no slot 2 access, MA outputs are a bubble, FSM is RUN, and the next pair serializes normally.
- Async rst pulse mid-SECOND, between clock edges → all outputs are 0 immediately. The first post-reset single LHU at 0x2 of 0x80018002 gives 0x00008001.
